// File: rtl/seg_pkg.sv
// Shared glyph constants, FSM state type and anode helpers for seg_capture.
// Build option SEG_CAPTURE_HEX_EN adds the A..F glyphs.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low, bit order gfedcba
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
`ifdef SEG_CAPTURE_HEX_EN
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
`endif

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } seg_cap_state_t;

  function automatic logic one_hot_low(input logic [3:0] an);
    logic [3:0] act;
    act = ~an;
    return (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
  endfunction

  function automatic logic multi_low(input logic [3:0] an);
    logic [3:0] act;
    act = ~an;
    return (act & (act - 4'd1)) != 4'd0;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_capture_if.sv
// Bus between a multiplexed seven-segment driver and the seg_capture monitor.
interface seg_capture_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        digit_upd;
  logic [1:0]  upd_pos;
  logic [15:0] frame;
  logic        frame_valid;
  logic        err_pat;
  logic        err_an;

  modport master (
    output seg, an,
    input  digits, blank, digit_upd, upd_pos, frame, frame_valid, err_pat, err_an
  );

  modport slave (
    input  seg, an,
    output digits, blank, digit_upd, upd_pos, frame, frame_valid, err_pat, err_an
  );
endinterface

// File: rtl/seg_glyph_decode.sv
// Combinational seven-segment glyph to nibble decoder.
// SEG_CAPTURE_HEX_EN extends the legal set with A..F.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       legal,
  output logic       is_blank
);

  always_comb begin
    value    = 4'h0;
    legal    = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0: value = 4'h0;
      SEG_1: value = 4'h1;
      SEG_2: value = 4'h2;
      SEG_3: value = 4'h3;
      SEG_4: value = 4'h4;
      SEG_5: value = 4'h5;
      SEG_6: value = 4'h6;
      SEG_7: value = 4'h7;
      SEG_8: value = 4'h8;
      SEG_9: value = 4'h9;
`ifdef SEG_CAPTURE_HEX_EN
      SEG_A: value = 4'hA;
      SEG_B: value = 4'hB;
      SEG_C: value = 4'hC;
      SEG_D: value = 4'hD;
      SEG_E: value = 4'hE;
      SEG_F: value = 4'hF;
`endif
      SEG_BLANK: begin
        legal    = 1'b0;
        is_blank = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Readback monitor for a 4-digit multiplexed seven-segment bus: debounces seg/an,
// decodes digits per anode and emits complete frames. Hex glyphs via SEG_CAPTURE_HEX_EN.
module seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic          clk,
  input logic          rst_n,
  seg_capture_if.slave bus
);

  localparam logic [7:0] CntMax = 8'(STABLE_CYCLES);

  logic [6:0]     s_seg;
  logic [3:0]     s_an;
  logic [7:0]     cnt, cnt_d;
  logic [3:0]     seen, seen_d;
  seg_cap_state_t state, state_d;

  logic [15:0] digits_q, digits_d, frame_q;
  logic [3:0]  blank_q, blank_d;
  logic        upd_q, fv_q, err_pat_q, err_an_q;
  logic [1:0]  upd_pos_q, pos;

  logic       changed, full, accept, write, frame_done, anode_err;
  logic [3:0] glyph_val;
  logic       glyph_legal, glyph_blank;

  // Decisions look at the pair being registered this edge so acceptance lands
  // exactly STABLE_CYCLES-1 edges after the pair is first captured.
  seg_glyph_decode u_decode (
    .pattern  (bus.seg),
    .value    (glyph_val),
    .legal    (glyph_legal),
    .is_blank (glyph_blank)
  );

  always_comb begin
    changed = {bus.seg, bus.an} != {s_seg, s_an};
    if (changed) begin
      cnt_d = 8'd1;
    end else if (cnt >= CntMax) begin
      cnt_d = CntMax;
    end else begin
      cnt_d = cnt + 8'd1;
    end
    full      = (cnt_d == CntMax);
    accept    = one_hot_low(bus.an) && full && (changed || state != HELD);
    anode_err = multi_low(bus.an) && full && (changed || cnt != CntMax);

    if (!one_hot_low(bus.an)) begin
      state_d = WAIT;
    end else if (full) begin
      state_d = HELD;
    end else begin
      state_d = SETTLE;
    end
  end

  always_comb begin
    pos      = low_index(bus.an);
    write    = accept && (glyph_legal || glyph_blank);
    digits_d = digits_q;
    blank_d  = blank_q;
    seen_d   = seen;
    if (write) begin
      digits_d[{pos, 2'b00} +: 4] = glyph_val;
      blank_d[pos]                = glyph_blank;
      seen_d[pos]                 = 1'b1;
    end
    frame_done = write && (seen_d == 4'hF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg     <= SEG_BLANK;
      s_an      <= 4'hF;
      cnt       <= 8'd0;
      state     <= WAIT;
      seen      <= 4'h0;
      digits_q  <= 16'h0;
      blank_q   <= 4'hF;
      frame_q   <= 16'h0;
      upd_q     <= 1'b0;
      upd_pos_q <= 2'd0;
      fv_q      <= 1'b0;
      err_pat_q <= 1'b0;
      err_an_q  <= 1'b0;
    end else begin
      s_seg     <= bus.seg;
      s_an      <= bus.an;
      cnt       <= cnt_d;
      state     <= state_d;
      seen      <= frame_done ? 4'h0 : seen_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
      frame_q   <= frame_done ? digits_d : frame_q;
      upd_q     <= write;
      upd_pos_q <= write ? pos : upd_pos_q;
      fv_q      <= frame_done;
      err_pat_q <= accept && !glyph_legal && !glyph_blank;
      err_an_q  <= anode_err;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.blank       = blank_q;
  assign bus.digit_upd   = upd_q;
  assign bus.upd_pos     = upd_pos_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = fv_q;
  assign bus.err_pat     = err_pat_q;
  assign bus.err_an      = err_an_q;

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed table, reset-mid-scan sequence and random run
// checked against a run-length reference model.
module tb_seg_capture;

  localparam int N = 4;
`ifdef SEG_CAPTURE_HEX_EN
  localparam int NG = 16;
`else
  localparam int NG = 10;
`endif
  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_capture_if bus ();
  seg_capture #(.STABLE_CYCLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a pattern is accepted when its run length hits N.
  logic [6:0]  m_prev_seg;
  logic [3:0]  m_prev_an;
  int          m_run;
  logic [15:0] m_digits, m_frame;
  logic [3:0]  m_blank, m_seen;
  logic        m_upd, m_fv, m_ep, m_ea;
  logic [1:0]  m_pos;

  int n_upd, n_ep, n_ea, n_fv;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] sg);
    for (int i = 0; i < NG; i++) begin
      if (GLYPHS[i] == sg) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_prev_seg = 7'h7F;
    m_prev_an  = 4'hF;
    m_run      = 0;
    m_digits   = 16'h0;
    m_frame    = 16'h0;
    m_blank    = 4'hF;
    m_seen     = 4'h0;
    m_upd      = 1'b0;
    m_fv       = 1'b0;
    m_ep       = 1'b0;
    m_ea       = 1'b0;
    m_pos      = 2'd0;
  endtask

  task automatic model_edge(input logic [6:0] sg, input logic [3:0] a);
    int lows, p, v;
    m_upd = 1'b0;
    m_fv  = 1'b0;
    m_ep  = 1'b0;
    m_ea  = 1'b0;
    if (sg == m_prev_seg && a == m_prev_an) m_run++;
    else m_run = 1;
    m_prev_seg = sg;
    m_prev_an  = a;
    if (m_run != N) return;
    lows = 0;
    p    = 0;
    for (int i = 0; i < 4; i++) begin
      if (!a[i]) begin
        lows++;
        p = i;
      end
    end
    if (lows > 1) begin
      m_ea = 1'b1;
      return;
    end
    if (lows == 0) return;
    v = lookup(sg);
    if (sg == 7'h7F) v = 0;
    else if (v < 0) begin
      m_ep = 1'b1;
      return;
    end
    m_digits[4*p +: 4] = 4'(v);
    m_blank[p]         = (sg == 7'h7F);
    m_seen[p]          = 1'b1;
    m_upd              = 1'b1;
    m_pos              = 2'(p);
    if (m_seen == 4'hF) begin
      m_frame = m_digits;
      m_fv    = 1'b1;
      m_seen  = 4'h0;
    end
  endtask

  task automatic check_outputs();
    chk("digits", bus.digits, m_digits);
    chk("blank", 16'(bus.blank), 16'(m_blank));
    chk("digit_upd", 16'(bus.digit_upd), 16'(m_upd));
    if (m_upd) chk("upd_pos", 16'(bus.upd_pos), 16'(m_pos));
    chk("frame", bus.frame, m_frame);
    chk("frame_valid", 16'(bus.frame_valid), 16'(m_fv));
    chk("err_pat", 16'(bus.err_pat), 16'(m_ep));
    chk("err_an", 16'(bus.err_an), 16'(m_ea));
  endtask

  task automatic cyc(input logic [6:0] sg, input logic [3:0] a);
    bus.seg = sg;
    bus.an  = a;
    @(posedge clk);
    model_edge(sg, a);
    @(negedge clk);
    check_outputs();
    n_upd += int'(bus.digit_upd);
    n_ep  += int'(bus.err_pat);
    n_ea  += int'(bus.err_an);
    n_fv  += int'(bus.frame_valid);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_digits"}, bus.digits, 16'h0);
    chk({tag, "_blank"}, 16'(bus.blank), 16'hF);
    chk({tag, "_upd"}, 16'(bus.digit_upd), 16'h0);
    chk({tag, "_upd_pos"}, 16'(bus.upd_pos), 16'h0);
    chk({tag, "_frame"}, bus.frame, 16'h0);
    chk({tag, "_fv"}, 16'(bus.frame_valid), 16'h0);
    chk({tag, "_err_pat"}, 16'(bus.err_pat), 16'h0);
    chk({tag, "_err_an"}, 16'(bus.err_an), 16'h0);
  endtask

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  an;
    int          hold;
    int          upd;
    int          ep;
    int          ea;
    int          fv;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs [11];

  logic [6:0] r_seg;
  logic [3:0] r_an;
  int         r_hold, r_sel;

  initial begin
    vecs[0] = '{7'h79, 4'hE, 10, 1, 0, 0, 0, 16'h0001, 4'hE, 16'h0000};
    vecs[1] = '{7'h24, 4'hD, 10, 1, 0, 0, 0, 16'h0021, 4'hC, 16'h0000};
    vecs[2] = '{7'h30, 4'hB, 10, 1, 0, 0, 0, 16'h0321, 4'h8, 16'h0000};
    vecs[3] = '{7'h19, 4'h7, 10, 1, 0, 0, 1, 16'h4321, 4'h0, 16'h4321};
    vecs[4] = '{7'h30, 4'hE, 3, 0, 0, 0, 0, 16'h4321, 4'h0, 16'h4321};
    vecs[5] = '{7'h12, 4'hD, 10, 1, 0, 0, 0, 16'h4351, 4'h0, 16'h4321};
    vecs[6] = '{7'h7F, 4'hB, 6, 1, 0, 0, 0, 16'h4051, 4'h4, 16'h4321};
`ifdef SEG_CAPTURE_HEX_EN
    vecs[7] = '{7'h08, 4'hD, 10, 1, 0, 0, 0, 16'h40A1, 4'h4, 16'h4321};
    vecs[8] = '{7'h40, 4'hC, 8, 0, 0, 1, 0, 16'h40A1, 4'h4, 16'h4321};
    vecs[9] = '{7'h00, 4'hE, 5, 1, 0, 0, 0, 16'h40A8, 4'h4, 16'h4321};
    vecs[10] = '{7'h10, 4'h7, 4, 1, 0, 0, 1, 16'h90A8, 4'h4, 16'h90A8};
`else
    vecs[7] = '{7'h08, 4'hD, 10, 0, 1, 0, 0, 16'h4051, 4'h4, 16'h4321};
    vecs[8] = '{7'h40, 4'hC, 8, 0, 0, 1, 0, 16'h4051, 4'h4, 16'h4321};
    vecs[9] = '{7'h00, 4'hE, 5, 1, 0, 0, 0, 16'h4058, 4'h4, 16'h4321};
    vecs[10] = '{7'h10, 4'h7, 4, 1, 0, 0, 1, 16'h9058, 4'h4, 16'h9058};
`endif

    bus.seg = 7'h7F;
    bus.an  = 4'hF;
    model_reset();
    #12;
    check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int v = 0; v < 11; v++) begin
      n_upd = 0;
      n_ep  = 0;
      n_ea  = 0;
      n_fv  = 0;
      repeat (vecs[v].hold) cyc(vecs[v].seg, vecs[v].an);
      chk($sformatf("row%0d_upd_count", v), 16'(n_upd), 16'(vecs[v].upd));
      chk($sformatf("row%0d_errpat_count", v), 16'(n_ep), 16'(vecs[v].ep));
      chk($sformatf("row%0d_erran_count", v), 16'(n_ea), 16'(vecs[v].ea));
      chk($sformatf("row%0d_fv_count", v), 16'(n_fv), 16'(vecs[v].fv));
      chk($sformatf("row%0d_digits", v), bus.digits, vecs[v].digits);
      chk($sformatf("row%0d_blank", v), 16'(bus.blank), 16'(vecs[v].blank));
      chk($sformatf("row%0d_frame", v), bus.frame, vecs[v].frame);
    end

    // Partial frame followed by reset: the three earlier positions must not count
    repeat (5) cyc(7'h12, 4'hE);
    repeat (5) cyc(7'h02, 4'hD);
    repeat (5) cyc(7'h78, 4'hB);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("mid_rst_async");
    @(posedge clk);
    @(negedge clk);
    check_reset_values("mid_rst_held");
    bus.seg = 7'h7F;
    bus.an  = 4'hF;
    rst_n   = 1'b1;
    n_fv = 0;
    n_upd = 0;
    repeat (5) cyc(7'h00, 4'hE);
    repeat (5) cyc(7'h10, 4'hD);
    repeat (5) cyc(7'h40, 4'hB);
    chk("post_rst_fv_early", 16'(n_fv), 16'd0);
    repeat (5) cyc(7'h79, 4'h7);
    chk("post_rst_upd_count", 16'(n_upd), 16'd4);
    chk("post_rst_fv_count", 16'(n_fv), 16'd1);
    chk("post_rst_frame", bus.frame, 16'h1098);

    // Random segments, including single-cycle glitches and bad anodes
    for (int k = 0; k < 300; k++) begin
      r_sel = int'($urandom_range(0, 9));
      if (r_sel < 6) r_seg = GLYPHS[$urandom_range(0, 15)];
      else if (r_sel < 8) r_seg = 7'h7F;
      else r_seg = 7'($urandom);
      r_an = 4'hF;
      if ($urandom_range(0, 9) < 8) r_an[$urandom_range(0, 3)] = 1'b0;
      else r_an = 4'($urandom);
      r_hold = int'($urandom_range(1, 7));
      repeat (r_hold) cyc(r_seg, r_an);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
# seg_capture

Scan-side decoder for the four-digit multiplexed seven-segment bus. It samples the active-low `seg`/`an` lines that the display driver produces and filters out transition glitches. It converts each stable segment pattern back into a 4-bit digit per anode position and emits a complete four-digit frame once every position has been refreshed. It sits beside the display driver as an on-chip readback monitor for the stopwatch, and is the bench's scoreboard source.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples needed to accept a pattern; legal range 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `seg`  in  7  segment lines, active-low, bit 0 = segment a; same clock domain as `clk`.
- `an`  in  4  anode enables, active-low; `an[i]` selects position i.
- `digits`  out  16  captured digit per position, `digits[4i+3:4i]` for position i.
- `blank`  out  4  position i last accepted an all-off pattern (7'h7F).
- `digit_upd`  out  1  one-cycle pulse: a position was accepted this cycle.
- `upd_pos`  out  2  index of the accepted position; meaningful only while `digit_upd` is high.
- `frame`  out  16  snapshot of `digits` taken at frame completion.
- `frame_valid`  out  1  one-cycle pulse: `frame` was just updated.
- `err_pat`  out  1  one-cycle pulse: a stable pattern was not a legal glyph.
- `err_an`  out  1  one-cycle pulse: `an` had more than one bit low for `STABLE_CYCLES` consecutive samples.

## Operation
- Input stage: `seg`/`an` are registered every cycle into `s_seg`/`s_an`. All further logic uses the registered pair.
- Stability counter `cnt`:
  - If the pair equals the previous registered pair, `cnt` increments, saturating at `STABLE_CYCLES`.
  - Otherwise `cnt` is set to 1.
- FSM states:
  - WAIT: `s_an` is not exactly one-hot-low.
  - SETTLE: `s_an` is one-hot-low and `cnt` < `STABLE_CYCLES`.
  - HELD: accepted; stays here until the pair changes.
- Transitions:
  - Any change of the pair goes to SETTLE if `s_an` is one-hot-low, otherwise to WAIT.
  - SETTLE goes to HELD when `cnt` reaches `STABLE_CYCLES`. The acceptance actions fire on that transition.
  - HELD never re-accepts. The same position after another position, or after a glitch, counts as a new acceptance.
- Acceptance at position p:
  - Legal glyph: `digits[p]` is set to the decoded value, `blank[p]`=0, `seen[p]`=1, `digit_upd`=1, `upd_pos`=p.
  - 7'h7F: `digits[p]`=0, `blank[p]`=1, `seen[p]`=1, `digit_upd`=1.
  - Illegal pattern: `err_pat`=1. `digits`, `blank` and `seen` are unchanged, and `digit_upd` stays 0.
- Legal glyphs for 0..9 (active-low, gfedcba): 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
- Frame completion: when an acceptance makes `seen`==4'hF:
  - `frame` takes `digits` including the digit written on that same edge.
  - `frame_valid`=1 and `seen` clears to 0.
  - Re-accepting a position before the frame completes overwrites that digit and leaves `seen` unchanged.
- Multiple anodes low: the state is WAIT. `err_an` pulses once when `cnt` reaches `STABLE_CYCLES` and does not pulse again until the pair changes.
- Reset values:
  - Outputs: `digits`=0, `blank`=4'hF, `digit_upd`=0, `upd_pos`=0, `frame`=0, `frame_valid`=0, `err_pat`=0, `err_an`=0.
  - Internal: `s_seg`=7'h7F, `s_an`=4'hF, `cnt`=0, `seen`=0, state WAIT.
- Reset asserted mid-scan returns everything to the reset values immediately. Any partial frame is discarded.

## Timing
- If a new pair is first registered at edge E, the acceptance actions take effect at edge E+`STABLE_CYCLES`-1. Pulses are visible for the following cycle.
- With `STABLE_CYCLES`=1, acceptance happens on the edge that first registers the pair.
- `frame_valid` coincides with the `digit_upd` of the completing position.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SEG_CAPTURE_HEX_EN` defined:
  - Also accepts A..F as 08, 03, 46, 21, 06, 0E (hex) and decodes them to 4'hA..4'hF.
  - Decode order is the 0..9 table first, then A..F.
- Undefined: those patterns are illegal and raise `err_pat`.

## Structure
- Shared package `seg_pkg`:
  - `SEG_BLANK`=7'h7F.
  - Glyph constants `SEG_0`..`SEG_9` and, under the macro, `SEG_A`..`SEG_F`.
  - State enum `seg_cap_state_t` {WAIT, SETTLE, HELD}.
- One combinational sub-module, `seg_glyph_decode`: input 7-bit pattern; outputs 4-bit value, `legal`, `is_blank`.

## Test plan
- Scan 1,2,3,4 on `an`=E,D,B,7, each held 10 cycles with `STABLE_CYCLES`=4 -> four `digit_upd` pulses with `upd_pos` 0..3; `frame`=16'h4321 with `frame_valid` coincident with the fourth `digit_upd`.
- Hold `an`=E with `seg`=30 for only 3 cycles, then switch to position 1 -> no acceptance for position 0; `digits[3:0]` keeps its old value.
- `seg`=7'h7F on position 2 for 6 cycles -> `blank[2]`=1, `digits[11:8]`=0, one `digit_upd`.
- `seg`=7'h08 on position 1 -> without the macro: `err_pat` pulse, no `digit_upd`; with the macro: `digits[7:4]`=4'hA.
- `an`=4'hC held 8 cycles -> exactly one `err_an` pulse, no `digit_upd`.
- Complete 3 positions, then pulse `rst_n` low for 1 cycle, then scan all 4 -> `frame_valid` only after all 4 new acceptances; all outputs at reset values during reset.
